// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//   Fetch-side branch predictor and redirect controller for an RV32I pipeline.
//   A direct-mapped BTB with 2-bit saturating counters is looked up with the
//   fetch PC. Branches resolved in EX train the table. A mispredict raises the
//   recovery signals and opens a short flush window. During that window EX
//   results are ignored because they belong to the wrong path.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   pc_f                         fetch PC to look up
//   stall                        freezes table updates, FSM and counters
//   pred_sel, pred_addr          predicted next-PC select and address
//   ex_valid, ex_branch, ex_pc   resolving instruction in EX
//   ex_taken, ex_target          resolved direction and taken target
//   ex_pred_taken, ex_pred_addr  prediction carried down with the instruction
//   mispredict, pc_back          redirect flag and recovery PC for the PC mux
//   flush                        kill IF/ID this cycle
//   br_count, mp_count           saturating resolved-branch / mispredict counts
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int ENTRIES      = 16,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall,
  output logic        pred_sel,
  output logic [31:0] pred_addr,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_addr,
  output logic        mispredict,
  output logic [31:0] pc_back,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] br_count_q, mp_count_q;

  // ---------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[31:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_sel  = f_hit && ctr_q[f_idx][1];
  assign pred_addr = f_hit ? target_q[f_idx] : (pc_f + 32'd4);

  // ---------------------------------------------------------------------
  // Resolve
  // ---------------------------------------------------------------------
  logic             res;
  logic             upd_en;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  assign res    = ex_valid && ex_branch && (state_q == RUN);
  assign upd_en = res && !stall;
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A correct "taken" guess still redirects if it steered fetch to a stale target.
  assign mispredict = res && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_pred_addr != ex_target)));
  assign pc_back    = ex_taken ? ex_target : (ex_pc + 32'd4);
  assign flush      = mispredict || (state_q == FLUSH);

  // ---------------------------------------------------------------------
  // Table update: valid and counters carry reset state, tag/target do not
  // need it because valid gates every use of them.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
        end else begin
          if (ctr_q[ex_idx] != 2'b00) ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Hit-and-taken and miss-and-taken both write the resolved target.
  always_ff @(posedge clk) begin
    if (upd_en && ex_taken) begin
      target_q[ex_idx] <= ex_target;
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
    end
  end

  // ---------------------------------------------------------------------
  // Flush-window FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (mispredict) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end
        end
        FLUSH: begin
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Statistics counters (saturating)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q <= 32'd0;
      mp_count_q <= 32'd0;
    end else if (!stall) begin
      if (res && (br_count_q != 32'hFFFF_FFFF))        br_count_q <= br_count_q + 32'd1;
      if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) mp_count_q <= mp_count_q + 32'd1;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

  // Byte-offset bits of the PCs carry no information for word-aligned code.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall;
  logic        pred_sel;
  logic [31:0] pred_addr;
  logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_addr;
  logic        mispredict;
  logic [31:0] pc_back;
  logic        flush;
  logic [31:0] br_count, mp_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: BTB as plain arrays, flush window as "cycles remaining".
  bit          m_valid [16];
  int          m_ctr   [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_flush_rem;
  logic [31:0] m_br, m_mp;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.ENTRIES(16), .IDX_W(4), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .stall(stall),
    .pred_sel(pred_sel), .pred_addr(pred_addr),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_addr(ex_pred_addr),
    .mispredict(mispredict), .pc_back(pc_back), .flush(flush),
    .br_count(br_count), .mp_count(mp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
    end
    m_flush_rem = 0;
    m_br = 32'd0;
    m_mp = 32'd0;
  endtask

  // Model's own prediction for a PC (used to build realistic carried-down predictions).
  task automatic model_predict(input logic [31:0] pc, output logic ps, output logic [31:0] pa);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == (pc >> 6));
    ps  = hit && (m_ctr[i] >= 2);
    pa  = hit ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] pa);
    ex_valid = v; ex_branch = v; ex_pc = pc; ex_taken = t;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_addr = pa;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, clock, advance model,
  // check counters just after the edge.
  task automatic tick();
    logic        e_ps, e_mp, e_fl, res;
    logic [31:0] e_pa, e_pb;
    int          i;
    bit          hit;
    @(negedge clk);
    model_predict(pc_f, e_ps, e_pa);
    res  = ex_valid && ex_branch && (m_flush_rem == 0);
    e_mp = res && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_addr != ex_target)));
    e_pb = ex_taken ? ex_target : ex_pc + 32'd4;
    e_fl = e_mp || (m_flush_rem > 0);
    chk("pred_sel",   {31'd0, pred_sel},   {31'd0, e_ps});
    chk("pred_addr",  pred_addr,           e_pa);
    chk("mispredict", {31'd0, mispredict}, {31'd0, e_mp});
    chk("pc_back",    pc_back,             e_pb);
    chk("flush",      {31'd0, flush},      {31'd0, e_fl});
    @(posedge clk);
    #1;
    if (!stall) begin
      if (m_flush_rem > 0) begin
        m_flush_rem--;
      end else if (res) begin
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (e_mp && m_mp != 32'hFFFF_FFFF) m_mp++;
        i   = idx_of(ex_pc);
        hit = m_valid[i] && (m_tag[i] == (ex_pc >> 6));
        if (hit) begin
          m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (ex_taken) m_tgt[i] = ex_target;
        end else if (ex_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = ex_pc >> 6;
          m_tgt[i]   = ex_target;
          m_ctr[i]   = 2;
        end
        if (e_mp) m_flush_rem = FLUSH_CYCLES;
      end
    end
    chk("br_count", br_count, m_br);
    chk("mp_count", mp_count, m_mp);
  endtask

  initial begin
    logic        ps;
    logic [31:0] pa, rpc, rtgt;
    logic        rt;

    // 1. Reset state
    rst = 1'b1; stall = 1'b0; pc_f = 32'h100;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    #12;
    chk("rst_pred_sel",  {31'd0, pred_sel}, 32'd0);
    chk("rst_pred_addr", pred_addr,         32'h104);
    chk("rst_flush",     {31'd0, flush},    32'd0);
    chk("rst_br_count",  br_count,          32'd0);
    chk("rst_mp_count",  mp_count,          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2. Taken branch predicted not-taken -> allocate, redirect, 1+2 flush cycles
    set_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    chk("t2_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t2_pc_back",    pc_back,             32'h80);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1; chk("t2_flush_w1", {31'd0, flush}, 32'd1); tick();
    #1; chk("t2_flush_w2", {31'd0, flush}, 32'd1); tick();
    #1; chk("t2_flush_end", {31'd0, flush}, 32'd0);
    chk("t2_pred_sel",  {31'd0, pred_sel}, 32'd1);
    chk("t2_pred_addr", pred_addr,         32'h80);

    // 3. Correct taken (ctr 2->3), not-taken mispredicted (3->2), not-taken correct (2->1)
    set_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    #1; chk("t3_correct", {31'd0, mispredict}, 32'd0); tick();
    set_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1; chk("t3_nt_mp", {31'd0, mispredict}, 32'd1);
    chk("t3_pc_back", pc_back, 32'h104); tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    set_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    #1; chk("t3_nt_ok", {31'd0, mispredict}, 32'd0); tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1; chk("t3_pred_drop", {31'd0, pred_sel}, 32'd0);

    // 4. Right direction, stale target -> mispredict and target rewrite
    set_ex(1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h90);
    #1; chk("t4_target_mp", {31'd0, mispredict}, 32'd1); tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    #1; chk("t4_new_target", pred_addr, 32'hC0);

    // 5. Mispredict, stall 3 cycles, then a resolve inside FLUSH is ignored
    set_ex(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("t5_stall_flush", {31'd0, flush}, 32'd1); tick();
    end
    stall = 1'b0;
    pc_f = 32'h240;
    set_ex(1'b1, 32'h240, 1'b1, 32'h400, 1'b0, 32'h244);
    #1; chk("t5_ignored_mp", {31'd0, mispredict}, 32'd0); tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    #1; chk("t5_no_alloc", {31'd0, pred_sel}, 32'd0);

    // 6. Reset asserted mid-FLUSH
    pc_f = 32'h100;
    set_ex(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1; chk("t6_in_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_flush_cleared", {31'd0, flush},    32'd0);
    chk("t6_btb_empty",     {31'd0, pred_sel}, 32'd0);
    chk("t6_br_cleared",    br_count,          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      pc_f  = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
      stall = ($urandom_range(0, 4) == 0);
      rpc   = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
      rtgt  = 32'h2000 + ($urandom_range(0, 7) << 2);
      rt    = $urandom_range(0, 1) == 1;
      model_predict(rpc, ps, pa);
      if ($urandom_range(0, 3) == 0) begin
        ps = $urandom_range(0, 1) == 1;
        pa = 32'h2000 + ($urandom_range(0, 7) << 2);
      end
      set_ex($urandom_range(0, 4) != 0, rpc, rt, rtgt, ps, pa);
      ex_branch = $urandom_range(0, 5) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
